// File: rtl/grasspopper_pkg.sv
// Shared constants for the Grasspopper linear layer.
// Contents: GF(2^8) polynomial, L coefficients, round count and FSM encoding.
package grasspopper_pkg;

  localparam int ROUNDS = 16;

  localparam logic [8:0] GF_POLY = 9'h1C3;

  // Indexed by byte position k, so LT_COEF[k] multiplies a_k.
  localparam logic [7:0] LT_COEF [16] = '{
    8'd1,   8'd148, 8'd32,  8'd133, 8'd16,  8'd194, 8'd192, 8'd1,
    8'd251, 8'd1,   8'd192, 8'd194, 8'd16,  8'd133, 8'd32,  8'd148
  };

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } lt_state_e;

  // Multiply in GF(2^8). With a constant c, synthesis reduces this to an XOR network.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) acc ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY[7:0] : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/r_step.sv
// One combinational Kuznyechik R step.
// Operation: the feedback byte l(a) enters at a15, and a0 is dropped.
module r_step
  import grasspopper_pkg::*;
(
  input  logic [127:0] data_i,
  output logic [127:0] data_o
);

  logic [7:0] fb;

  // NOTE: combinational logic uses blocking '=', and fb is given a default before the loop so no latch is inferred.
  always_comb begin
    fb = '0;
    for (int k = 0; k < 16; k++) begin
      fb ^= gf_mul(data_i[8*k +: 8], LT_COEF[k]);
    end
  end

  assign data_o = {fb, data_i[127:8]};

endmodule

// File: rtl/linear_transform_iter.sv
// Iterative Kuznyechik L transform: accepts a block, applies ROUNDS R steps, then holds the result.
// Define LT_UNROLL2_EN to take two chained R steps per BUSY cycle.
module linear_transform_iter #(
  parameter int ROUNDS = grasspopper_pkg::ROUNDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] data_o
);

  import grasspopper_pkg::lt_state_e;
  import grasspopper_pkg::S_IDLE;
  import grasspopper_pkg::S_BUSY;
  import grasspopper_pkg::S_DONE;

  lt_state_e    fsm_q;
  logic [127:0] state_q;
  logic [127:0] step_d;
  logic [3:0]   cnt_q;
  logic         valid_q;

`ifdef LT_UNROLL2_EN
  localparam logic [3:0] STEP_INC = 4'd2;
  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 2);

  logic [127:0] mid;

  r_step u_step0 (.data_i(state_q), .data_o(mid));
  r_step u_step1 (.data_i(mid),     .data_o(step_d));
`else
  localparam logic [3:0] STEP_INC = 4'd1;
  localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

  r_step u_step0 (.data_i(state_q), .data_o(step_d));
`endif

  // NOTE: all state uses non-blocking '<=', and reset is synchronous because rst is sampled only at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      case (fsm_q)
        S_IDLE: begin
          if (valid_i) begin
            state_q <= data_i;
            cnt_q   <= '0;
            fsm_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          state_q <= step_d;
          // The counter holds at its last value, so it never wraps inside BUSY.
          if (cnt_q == LAST_CNT) begin
            fsm_q   <= S_DONE;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + STEP_INC;
          end
        end
        S_DONE: begin
          if (ready_i) begin
            fsm_q   <= S_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          fsm_q   <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ready_o is masked by rst so that a block offered during reset is never accepted.
  assign ready_o = (fsm_q == S_IDLE) && !rst;
  assign valid_o = valid_q;
  assign data_o  = valid_q ? state_q : '0;

endmodule

// File: tb/tb_linear_transform_iter.sv
// Self-checking bench for linear_transform_iter, with a byte-level reference model of L.
// It expects 8-cycle latency when LT_UNROLL2_EN is defined, and 16-cycle latency otherwise.
module tb_linear_transform_iter;

`ifdef LT_UNROLL2_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif
  localparam int THRU = LAT + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] data_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] data_o;
  logic [127:0] probe_in;
  logic [127:0] probe_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  linear_transform_iter dut (
    .clk    (clk),
    .rst    (rst),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_i (data_i),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .data_o (data_o)
  );

  r_step u_probe (.data_i(probe_in), .data_o(probe_out));

  // Coefficients listed c15 down to c0.
  byte unsigned coef_hi2lo [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                                    1, 192, 194, 16, 133, 32, 148, 1};

  function automatic logic [7:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (y[i]) p ^= 16'(x) << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h01C3 << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_r(input logic [127:0] blk);
    byte unsigned a [16];
    logic [7:0]   l;
    for (int k = 0; k < 16; k++) a[k] = blk[8*k +: 8];
    l = 8'h00;
    for (int k = 0; k < 16; k++) l ^= ref_mul(a[k], coef_hi2lo[15-k]);
    return {l, blk[127:8]};
  endfunction

  function automatic logic [127:0] ref_l(input logic [127:0] blk);
    logic [127:0] s;
    s = blk;
    for (int r = 0; r < 16; r++) s = ref_r(s);
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 128'(ready_o), 128'd1);
  endtask

  // Send one block with ready_i high, then check latency, result and the return to IDLE.
  task automatic do_block(input logic [127:0] d, input logic [127:0] exp, input string tag);
    int lat;
    wait_ready(tag);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
    data_i  = rand128();
    lat = 0;
    while (!valid_o && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(LAT));
    check({tag, "_data"}, data_o, exp);
    tick();
    check({tag, "_valid_drop"}, 128'(valid_o), 128'd0);
    check({tag, "_data_zero"}, data_o, 128'd0);
    check({tag, "_ready_back"}, 128'(ready_o), 128'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    logic [127:0] held;
    logic [127:0] in_q [$];
    logic [127:0] exp_q [$];
    int           lat;
    int           acc_n;
    int           out_n;
    int           last_acc;
    logic         acc;
    logic         outv;
    logic [127:0] obs;

    rst     = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;

    // The R step, checked through a standalone r_step instance.
    probe_in = 128'h00000000000000000000000000000100;
    #1;
    check("r_step_vector", probe_out, 128'h94000000000000000000000000000001);
    for (int i = 0; i < 4; i++) begin
      probe_in = rand128();
      #1;
      check("r_step_rand", probe_out, ref_r(probe_in));
    end

    // Reset state.
    repeat (3) tick();
    check("rst_ready", 128'(ready_o), 128'd0);
    check("rst_valid", 128'(valid_o), 128'd0);
    check("rst_data", data_o, 128'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 128'(ready_o), 128'd1);

    // Known-answer L test, followed by the zero block.
    ready_i = 1'b1;
    do_block(128'h64a59400000000000000000000000000,
             128'hd456584dd0e3e84cc3166e4b7fa2890d, "gost");
    do_block(128'h0, 128'h0, "zero");

    // Random blocks checked against the reference model.
    for (int i = 0; i < 4; i++) begin
      d = rand128();
      do_block(d, ref_l(d), "rand");
    end

    // Backpressure: the result must stay stable in DONE, and a valid_i pulse there must be ignored.
    ready_i = 1'b0;
    d = rand128();
    wait_ready("bp");
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 200) begin
      tick();
      lat++;
    end
    check("bp_latency", 128'(lat), 128'(LAT));
    held = data_o;
    check("bp_data", held, ref_l(d));
    for (int i = 0; i < 5; i++) begin
      valid_i = (i == 2);
      data_i  = rand128();
      tick();
      check("bp_valid_hold", 128'(valid_o), 128'd1);
      check("bp_data_hold", data_o, held);
      check("bp_ready_low", 128'(ready_o), 128'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    tick();
    check("bp_release_valid", 128'(valid_o), 128'd0);
    check("bp_release_ready", 128'(ready_o), 128'd1);
    repeat (3) tick();
    check("bp_no_phantom", 128'(ready_o), 128'd1);
    check("bp_no_phantom_valid", 128'(valid_o), 128'd0);

    // Reset at BUSY cycle 7 must discard the in-flight block.
    d = rand128();
    wait_ready("mid_rst");
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
    repeat (6) tick();
    check("mid_rst_busy", 128'(ready_o), 128'd0);
    rst     = 1'b1;
    valid_i = 1'b1;
    data_i  = rand128();
    #1;
    check("mid_rst_ready_masked", 128'(ready_o), 128'd0);
    tick();
    valid_i = 1'b0;
    rst     = 1'b0;
    #1;
    check("mid_rst_idle", 128'(ready_o), 128'd1);
    check("mid_rst_valid", 128'(valid_o), 128'd0);
    check("mid_rst_data", data_o, 128'd0);
    d = rand128();
    do_block(d, ref_l(d), "after_rst");

    // Back-to-back: three blocks offered continuously.
    for (int i = 0; i < 3; i++) begin
      in_q.push_back(rand128());
      exp_q.push_back(ref_l(in_q[i]));
    end
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    data_i   = in_q[0];
    acc_n    = 0;
    out_n    = 0;
    last_acc = -1;
    for (int cyc = 0; cyc < 200 && out_n < 3; cyc++) begin
      acc  = valid_i && ready_o;
      outv = valid_o && ready_i;
      obs  = data_o;
      tick();
      if (acc) begin
        if (last_acc >= 0) check("b2b_gap", 128'(cyc - last_acc), 128'(THRU));
        last_acc = cyc;
        acc_n++;
        if (acc_n < 3) data_i = in_q[acc_n];
        else valid_i = 1'b0;
      end
      if (outv) begin
        check("b2b_data", obs, exp_q[out_n]);
        out_n++;
      end
    end
    valid_i = 1'b0;
    check("b2b_accepted", 128'(acc_n), 128'd3);
    check("b2b_outputs", 128'(out_n), 128'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
